risc16_exec_mem_stage: RTL and testbench

Execute/memory stage of the 16-bit RISC datapath.
- Decodes ALUOp plus instruction opcode into a 3-bit ALU operation.
- Performs the 16-bit ALU operation and the zero-flag test.
- Accesses a small word-addressed data memory using the ALU result as address.
- Sits between the register file/operand muxes and the write-back mux; zero feeds branch (beq/bne) logic.

---
 rtl/risc16_pkg.sv | 33 +++
 rtl/risc16_data_ram.sv | 33 +++
 rtl/risc16_exec_mem_stage.sv | 90 +++++++++
 tb/tb_risc16_exec_mem_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/risc16_pkg.sv
// Shared definitions for the 16-bit RISC datapath: ALUOp codes, opcodes, ALU op enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc16_pkg;

  // ALUOp values driven by main control
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_MEM   = 2'b10;

  // Instruction opcodes (instr[15:12]) that select a distinct R-type ALU operation
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_INV = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1001;

  // 3-bit ALU operation codes
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INV = 3'd2,
    ALU_SHL = 3'd3,
    ALU_SHR = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

endpackage

// File: rtl/risc16_data_ram.sv
// Small word-addressed data memory: sync write, combinational gated read, async clear.
// Latency: read 0 cycles; a write is visible after the edge that captures it.
// Backpressure: none; every enabled write is accepted.
// Ports: clk, rst_n (async clear of all words), we/wdata (write), re/rdata (read), addr.
module risc16_data_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Reset wins over a coincident write edge and holds writes off while low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // No write bypass: same-address read shows the old word until the edge.
  assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/risc16_exec_mem_stage.sv
// Execute/memory stage: ALU control decode, 16-bit ALU with zero flag, data memory access.
// Latency: decode/ALU/read 0 cycles; memory write visible one edge after issue.
// Backpressure: none; purely combinational apart from the data memory.
// Ports: alu_op/opcode -> alu_cnt; a,b -> alu_result, zero; mem_write/mem_read/
//        mem_write_data -> mem_read_data, addressed by alu_result[ADDR_BITS-1:0].
module risc16_exec_mem_stage
  import risc16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            alu_op,
  input  logic [3:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write,
  input  logic                  mem_read,
  output logic [2:0]            alu_cnt,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] mem_read_data
);

  alu_op_e               alu_sel;
  logic [DATA_WIDTH-1:0] alu_res;

  // ALU control: memory ops add, branches subtract, R-type decodes the opcode.
  always_comb begin
    alu_sel = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: alu_sel = ALU_ADD;
      ALUOP_BR:  alu_sel = ALU_SUB;
      ALUOP_RTYPE: begin
        case (opcode)
          OP_ADD:  alu_sel = ALU_ADD;
          OP_SUB:  alu_sel = ALU_SUB;
          OP_INV:  alu_sel = ALU_INV;
          OP_SHL:  alu_sel = ALU_SHL;
          OP_SHR:  alu_sel = ALU_SHR;
          OP_AND:  alu_sel = ALU_AND;
          OP_OR:   alu_sel = ALU_OR;
          OP_SLT:  alu_sel = ALU_SLT;
          default: alu_sel = ALU_ADD;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

  assign alu_cnt = alu_sel;

  // Shifts use the full b as amount; SV shift semantics give 0 for b >= width.
  always_comb begin
    alu_res = '0;
    case (alu_sel)
      ALU_ADD: alu_res = a + b;
      ALU_SUB: alu_res = a - b;
      ALU_INV: alu_res = ~a;
      ALU_SHL: alu_res = a << b;
      ALU_SHR: alu_res = a >> b;
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_SLT: alu_res = (a < b) ? DATA_WIDTH'(1) : '0;
      default: alu_res = '0;
    endcase
  end

  assign alu_result = alu_res;
  assign zero       = (alu_res == '0);

  // Upper result bits are dropped, so addresses wrap modulo MEM_DEPTH.
  risc16_data_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_data_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_write),
    .re    (mem_read),
    .addr  (alu_res[ADDR_BITS-1:0]),
    .wdata (mem_write_data),
    .rdata (mem_read_data)
  );

endmodule

// File: tb/tb_risc16_exec_mem_stage.sv
// Randomized and directed stimulus against a behavioural model of the exec/mem stage.
// Latency: expected outputs checked mid-cycle after each issue.
// Backpressure: none.
module tb_risc16_exec_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [3:0]  opcode;
  logic [15:0] a, b, mem_write_data;
  logic        mem_write, mem_read;
  logic [2:0]  alu_cnt;
  logic [15:0] alu_result;
  logic        zero;
  logic [15:0] mem_read_data;

  risc16_exec_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_op         (alu_op),
    .opcode         (opcode),
    .a              (a),
    .b              (b),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .alu_cnt        (alu_cnt),
    .alu_result     (alu_result),
    .zero           (zero),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [15:0] res;
    logic        z;
    logic [15:0] rd;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Behavioural model state: plain array of words
  longint model_mem[8];

  function automatic int model_cnt(input int op, input int opc);
    if (op == 1) return 1;
    if (op == 0 && opc >= 2 && opc <= 9) return opc - 2;
    return 0;
  endfunction

  function automatic longint model_res(input int cnt, input longint x, input longint y);
    case (cnt)
      0: return (x + y) % 65536;
      1: return (x - y + 65536) % 65536;
      2: return 65535 - x;
      3: return (y >= 16) ? 0 : (x * (longint'(1) << y)) % 65536;
      4: return (y >= 16) ? 0 : x / (longint'(1) << y);
      5: return x & y;
      6: return x | y;
      default: return (x < y) ? 1 : 0;
    endcase
  endfunction

  task automatic issue(input string nm, input logic r, input logic [1:0] op, input logic [3:0] opc,
                       input logic [15:0] av, input logic [15:0] bv,
                       input logic mw, input logic mr, input logic [15:0] wd);
    exp_t   e;
    int     c;
    longint res;
    rst_n = r; alu_op = op; opcode = opc; a = av; b = bv;
    mem_write = mw; mem_read = mr; mem_write_data = wd;
    if (!r) for (int i = 0; i < 8; i++) model_mem[i] = 0;
    c   = model_cnt(int'(op), int'(opc));
    res = model_res(c, longint'(av), longint'(bv));
    e.cnt = 3'(c);
    e.res = 16'(res);
    e.z   = (res == 0);
    e.rd  = mr ? 16'(model_mem[res % 8]) : 16'h0000;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    if (r && mw) model_mem[res % 8] = longint'(wd);
    #1;
  endtask

  // Monitor: outputs are combinational, so each issued transaction is sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (alu_cnt !== e.cnt) begin
        errors++;
        $display("FAIL %s alu_cnt: got %b expected %b", nm, alu_cnt, e.cnt);
      end
      checks++;
      if (alu_result !== e.res) begin
        errors++;
        $display("FAIL %s alu_result: got %h expected %h", nm, alu_result, e.res);
      end
      checks++;
      if (zero !== e.z) begin
        errors++;
        $display("FAIL %s zero: got %b expected %b", nm, zero, e.z);
      end
      checks++;
      if (mem_read_data !== e.rd) begin
        errors++;
        $display("FAIL %s mem_read_data: got %h expected %h", nm, mem_read_data, e.rd);
      end
    end
  end

  initial begin
    logic [15:0] wd;
    for (int i = 0; i < 8; i++) model_mem[i] = 0;
    rst_n = 1'b0; alu_op = 2'b10; opcode = 4'h0; a = 16'h0; b = 16'h0;
    mem_write = 1'b0; mem_read = 1'b0; mem_write_data = 16'h0;
    @(posedge clk); #1;

    // Reset state: ALU follows inputs, read data is 0
    issue("reset_rd", 1'b0, 2'b10, 4'h0, 16'h0004, 16'h0002, 1'b0, 1'b1, 16'h0);
    // Memory add, store then load at address 6
    issue("mem_wr", 1'b1, 2'b10, 4'h0, 16'h0004, 16'h0002, 1'b1, 1'b0, 16'hBEEF);
    issue("mem_rd", 1'b1, 2'b10, 4'h0, 16'h0004, 16'h0002, 1'b0, 1'b1, 16'h0);
    // Branch compare
    issue("beq_eq", 1'b1, 2'b01, 4'h0, 16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0);
    issue("beq_ne", 1'b1, 2'b01, 4'h0, 16'h0005, 16'h0003, 1'b0, 1'b0, 16'h0);
    // R-type opcode sweep
    for (int op = 2; op <= 9; op++)
      issue($sformatf("rtype_op%0d", op), 1'b1, 2'b00, 4'(op), 16'h00F0, 16'h0004, 1'b0, 1'b0, 16'h0);
    issue("slt_true", 1'b1, 2'b00, 4'b1001, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0);
    issue("op_other", 1'b1, 2'b00, 4'b0000, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h0);
    issue("aluop_11", 1'b1, 2'b11, 4'b0011, 16'h0010, 16'h0001, 1'b0, 1'b0, 16'h0);
    // Edge cases
    issue("add_wrap", 1'b1, 2'b10, 4'h0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0);
    issue("sub_wrap", 1'b1, 2'b01, 4'h0, 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0);
    issue("shl_16", 1'b1, 2'b00, 4'b0101, 16'hFFFF, 16'd16, 1'b0, 1'b0, 16'h0);
    issue("shr_big", 1'b1, 2'b00, 4'b0110, 16'hFFFF, 16'd300, 1'b0, 1'b0, 16'h0);
    issue("shl_15", 1'b1, 2'b00, 4'b0101, 16'h0003, 16'd15, 1'b0, 1'b0, 16'h0);
    // Aliasing: address 0x000A hits word 2
    issue("alias_wr", 1'b1, 2'b10, 4'h0, 16'h0008, 16'h0002, 1'b1, 1'b0, 16'hCAFE);
    issue("alias_rd", 1'b1, 2'b10, 4'h0, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0);
    // Read-during-write to same address shows old word, then new
    issue("rdw_old", 1'b1, 2'b10, 4'h0, 16'h0002, 16'h0000, 1'b1, 1'b1, 16'h1357);
    issue("rdw_new", 1'b1, 2'b10, 4'h0, 16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0);
    // Fill all words, read back
    for (int i = 0; i < 8; i++) begin
      wd = 16'($urandom_range(1, 65535));
      issue($sformatf("fill%0d", i), 1'b1, 2'b10, 4'h0, 16'(i), 16'h0000, 1'b1, 1'b0, wd);
    end
    for (int i = 0; i < 8; i++)
      issue($sformatf("readback%0d", i), 1'b1, 2'b10, 4'h0, 16'(i), 16'h0000, 1'b0, 1'b1, 16'h0);
    // Mid-cycle reset clears everything; write while in reset is ignored
    issue("rst_rd3", 1'b0, 2'b10, 4'h0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0);
    issue("rst_wr5", 1'b0, 2'b10, 4'h0, 16'h0005, 16'h0000, 1'b1, 1'b1, 16'hAAAA);
    for (int i = 0; i < 8; i++)
      issue($sformatf("post_rst%0d", i), 1'b1, 2'b10, 4'h0, 16'(i), 16'h0000, 1'b0, 1'b1, 16'h0);
    issue("rd_off_wr", 1'b1, 2'b10, 4'h0, 16'h0001, 16'h0000, 1'b1, 1'b0, 16'h5A5A);
    issue("rd_off", 1'b1, 2'b10, 4'h0, 16'h0001, 16'h0000, 1'b0, 1'b0, 16'h0);
    issue("rd_on", 1'b1, 2'b10, 4'h0, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0);

    // Random traffic, occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      issue("random", ($urandom_range(0, 29) != 0), 2'($urandom), 4'($urandom), ra, rb,
            1'($urandom), 1'($urandom), 16'($urandom));
    end

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d transactions unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
